cb_col_receiver: RTL

//  - Receive end of one crossbar column output: takes {queue_sel, dout, dat_valid} words, files them into the shared buffer.
//  - Shared buffer holds 32 logical queues (8 priorities x 4 dest ports); each queue is a fixed QDEPTH-word ring region.
//  - Keeps per-queue write pointer and occupancy; scheduler dequeue notifications release space.
//  - One instance per column (4 per switch), between the crossbar fabric and the shared-buffer write port.

---
 rtl/cb_col_receiver_pkg.sv | 38 +++
 rtl/cb_col_receiver_if.sv | 32 +++
 rtl/cb_rx_fifo.sv | 45 ++++
 rtl/cb_col_receiver.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cb_col_receiver_pkg.sv
// Shared definitions for the crossbar column receiver: widths, queue-select field layout,
// FSM state codes and small helpers.
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 32
`endif

package cb_col_receiver_pkg;

  localparam int unsigned DISPATCH_WIDTH = `DISPATCH_WIDTH;
  localparam int unsigned QSEL_W         = 5;
  localparam int unsigned NUM_Q          = 32;

  // queue_sel = {priority, dest_port}
  localparam int unsigned PRIO_MSB = 4;
  localparam int unsigned PRIO_LSB = 2;
  localparam int unsigned PORT_MSB = 1;
  localparam int unsigned PORT_LSB = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLook = 2'd1,
    StWr   = 2'd2
  } rx_state_e;

  function automatic logic [QSEL_W-1:0] qsel_make(input logic [2:0] prio,
                                                  input logic [1:0] port);
    logic [QSEL_W-1:0] q;
    q                    = '0;
    q[PRIO_MSB:PRIO_LSB] = prio;
    q[PORT_MSB:PORT_LSB] = port;
    return q;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cb_col_receiver_if.sv
// Column-side, shared-buffer-side and scheduler-side signals of one column receiver.
// The slave modport is the receiver; the master modport is its environment.
interface cb_col_receiver_if
  import cb_col_receiver_pkg::*;
#(
  parameter int unsigned DW  = DISPATCH_WIDTH,
  parameter int unsigned QAW = 4
);

  logic [QSEL_W-1:0]     cb_queue_sel;
  logic [DW-1:0]         cb_dout;
  logic                  cb_dat_valid;
  logic                  sb_wr_en;
  logic [QSEL_W+QAW-1:0] sb_wr_addr;
  logic [DW-1:0]         sb_wr_data;
  logic                  sb_wr_ready;
  logic                  deq_valid;
  logic [QSEL_W-1:0]     deq_qidx;
  logic [NUM_Q-1:0]      q_nonempty;
  logic                  err_underflow;

  modport slave (
    input  cb_queue_sel, cb_dout, cb_dat_valid, sb_wr_ready, deq_valid, deq_qidx,
    output sb_wr_en, sb_wr_addr, sb_wr_data, q_nonempty, err_underflow
  );

  modport master (
    output cb_queue_sel, cb_dout, cb_dat_valid, sb_wr_ready, deq_valid, deq_qidx,
    input  sb_wr_en, sb_wr_addr, sb_wr_data, q_nonempty, err_underflow
  );

endinterface

// File: rtl/cb_rx_fifo.sv
// Small synchronous skid FIFO; pushes into a full FIFO and pops from an empty one are ignored.
module cb_rx_fifo #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cb_col_receiver.sv
// Receive end of one crossbar column: files words into 32 per-queue ring regions of the shared
// buffer. Define CB_RX_STATS_EN to add saturating drop counters.
module cb_col_receiver
  import cb_col_receiver_pkg::*;
#(
  parameter int unsigned DW         = DISPATCH_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned QAW        = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cb_col_receiver_if.slave  bus_io
`ifdef CB_RX_STATS_EN
  ,
  output logic [15:0]       o_drop_fifo_cnt,
  output logic [15:0]       o_drop_qfull_cnt
`endif
);

  localparam int unsigned FW = QSEL_W + DW;
  localparam logic [QAW:0] OccFull = {1'b1, {QAW{1'b0}}};

  rx_state_e         state_q, state_d;
  logic [QSEL_W-1:0] hold_qidx_q, hold_qidx_d;
  logic [DW-1:0]     hold_data_q, hold_data_d;
  logic [QAW-1:0]    ptr_q [NUM_Q];
  logic [QAW-1:0]    ptr_d [NUM_Q];
  logic [QAW:0]      occ_q [NUM_Q];
  logic [QAW:0]      occ_d [NUM_Q];
  logic [NUM_Q-1:0]  deq_hit, nonempty_d, nonempty_q;
  logic              underflow_q, underflow_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_rdata;
  logic              wr_en, wr_hs, q_full;

  assign fifo_push = bus_io.cb_dat_valid && !fifo_full;

  cb_rx_fifo #(
    .Width (FW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push_i  (fifo_push),
    .wdata_i ({bus_io.cb_queue_sel, bus_io.cb_dout}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign q_full = (occ_q[hold_qidx_q] == OccFull);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StLook;
      StLook:  state_d = q_full ? StIdle : StWr;
      StWr:    if (bus_io.sb_wr_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath control
  always_comb begin
    fifo_pop    = 1'b0;
    wr_en       = 1'b0;
    wr_hs       = 1'b0;
    hold_qidx_d = hold_qidx_q;
    hold_data_d = hold_data_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          hold_qidx_d = fifo_rdata[FW-1 -: QSEL_W];
          hold_data_d = fifo_rdata[DW-1:0];
        end
      end
      StWr: begin
        wr_en = 1'b1;
        wr_hs = bus_io.sb_wr_ready;
      end
      default: ;
    endcase
  end

  // Address and data come straight from the holding regs; wr_ptr of the held queue can only
  // change on this FSM's own handshake, so they stay stable while the request is pending.
  assign bus_io.sb_wr_en      = wr_en;
  assign bus_io.sb_wr_addr    = {hold_qidx_q, ptr_q[hold_qidx_q]};
  assign bus_io.sb_wr_data    = hold_data_q;
  assign bus_io.q_nonempty    = nonempty_q;
  assign bus_io.err_underflow = underflow_q;

  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      deq_hit[q]    = bus_io.deq_valid && (bus_io.deq_qidx == QSEL_W'(q)) && (occ_q[q] != '0);
      ptr_d[q]      = ptr_q[q];
      occ_d[q]      = occ_q[q];
      nonempty_d[q] = (occ_q[q] != '0);
      if (wr_hs && (hold_qidx_q == QSEL_W'(q))) begin
        ptr_d[q] = ptr_q[q] + 1'b1;
        if (!deq_hit[q]) occ_d[q] = occ_q[q] + 1'b1;
      end else if (deq_hit[q]) begin
        occ_d[q] = occ_q[q] - 1'b1;
      end
    end
    underflow_d = underflow_q || (bus_io.deq_valid && (occ_q[bus_io.deq_qidx] == '0));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_qidx_q <= '0;
      hold_data_q <= '0;
      nonempty_q  <= '0;
      underflow_q <= 1'b0;
      for (int q = 0; q < NUM_Q; q++) begin
        ptr_q[q] <= '0;
        occ_q[q] <= '0;
      end
    end else begin
      hold_qidx_q <= hold_qidx_d;
      hold_data_q <= hold_data_d;
      nonempty_q  <= nonempty_d;
      underflow_q <= underflow_d;
      for (int q = 0; q < NUM_Q; q++) begin
        ptr_q[q] <= ptr_d[q];
        occ_q[q] <= occ_d[q];
      end
    end
  end

`ifdef CB_RX_STATS_EN
  logic [15:0] drop_fifo_q, drop_qfull_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_fifo_q  <= '0;
      drop_qfull_q <= '0;
    end else begin
      if (bus_io.cb_dat_valid && fifo_full) drop_fifo_q <= sat_inc16(drop_fifo_q);
      if ((state_q == StLook) && q_full)    drop_qfull_q <= sat_inc16(drop_qfull_q);
    end
  end

  assign o_drop_fifo_cnt  = drop_fifo_q;
  assign o_drop_qfull_cnt = drop_qfull_q;
`endif

endmodule
